// File: rtl/pid_pkg.sv
// Shared types, widths and the saturation helper for the PID sequencer.
// Optional feature macro used by pid_seq: PID_ANTIWINDUP_EN.
package pid_pkg;

  localparam int ERR_W  = 10;
  localparam int OUT_W  = 12;
  localparam int INT_W  = 15;
  localparam int P_W    = 14;
  localparam int D_W    = 13;
  localparam int DIFF_W = 7;
  localparam int COEF_W = 6;
  localparam int PROD_W = COEF_W + ERR_W;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_D,
    INTEG,
    SUM
  } state_e;

  // Clamp a sign-extended value to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pid_seq_sat.sv
// Parameterised signed saturator: clamps an IN_W-bit signed value into OUT_W bits.
// Used by pid_seq for the derivative difference, the integrator and the final sum.
module sat_signed #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [31:0] wide;

  always_comb begin
    wide = pid_pkg::sat_signed(32'(din), OUT_W);
    dout = OUT_W'(wide);
  end

endmodule

// File: rtl/pid_seq.sv
// PID term sequencer: one shared 6x10 signed multiplier, P/D/I terms summed and saturated.
// Build option: define PID_ANTIWINDUP_EN to freeze the integrator after a saturated output.
module pid_seq
  import pid_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] P_COEFF = 6'sh03,
  parameter logic signed [COEF_W-1:0] D_COEFF = 6'sh0B,
  parameter int                       I_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    err_vld,
  input  logic                    moving,
  output logic                    busy,
  output logic signed [OUT_W-1:0] pid_out,
  output logic                    pid_vld,
  output logic                    ovr
);

  localparam int ISUM_W = INT_W + 1;

  state_e                  state_q, state_d;
  logic signed [ERR_W-1:0] err_cur_q, err_cur_d;
  logic signed [ERR_W-1:0] prev_err_q, prev_err_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic signed [D_W-1:0]   d_q, d_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [OUT_W-1:0] pid_out_q, pid_out_d;
  logic                    pid_vld_q, pid_vld_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;
`ifdef PID_ANTIWINDUP_EN
  logic                    sat_last_q, sat_last_d;
  logic                    sum_sat;
`endif

  logic signed [ERR_W-1:0]  diff;
  logic signed [DIFF_W-1:0] diff_sat;
  logic signed [ISUM_W-1:0] integ_sum;
  logic signed [INT_W-1:0]  integ_clip;
  logic signed [INT_W-1:0]  sum;
  logic signed [OUT_W-1:0]  sum_clip;
  logic signed [COEF_W-1:0] mul_a;
  logic signed [ERR_W-1:0]  mul_b;
  logic signed [PROD_W-1:0] mul_prod;

  // Difference is deliberately kept at error width before the 7-bit clamp.
  assign diff      = err_cur_q - prev_err_q;
  assign integ_sum = ISUM_W'(integ_q) + ISUM_W'(err_cur_q);
  assign sum       = INT_W'(p_q) + (integ_q >>> I_SHIFT) + INT_W'(d_q);
`ifdef PID_ANTIWINDUP_EN
  assign sum_sat   = (sum != INT_W'(sum_clip));
`endif

  sat_signed #(.IN_W(ERR_W),  .OUT_W(DIFF_W)) u_sat_diff  (.din(diff),      .dout(diff_sat));
  sat_signed #(.IN_W(ISUM_W), .OUT_W(INT_W))  u_sat_integ (.din(integ_sum), .dout(integ_clip));
  sat_signed #(.IN_W(INT_W),  .OUT_W(OUT_W))  u_sat_sum   (.din(sum),       .dout(sum_clip));

  // Single multiplier: operands steered by state, P term by default.
  always_comb begin
    mul_a = P_COEFF;
    mul_b = err_cur_q;
    if (state_q == MUL_D) begin
      mul_a = D_COEFF;
      mul_b = ERR_W'(diff_sat);
    end
    mul_prod = PROD_W'(mul_a) * PROD_W'(mul_b);
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    err_cur_d  = err_cur_q;
    prev_err_d = prev_err_q;
    p_d        = p_q;
    d_d        = d_q;
    integ_d    = integ_q;
    pid_out_d  = pid_out_q;
    pid_vld_d  = 1'b0;
    busy_d     = busy_q;
    ovr_d      = ovr_q;
`ifdef PID_ANTIWINDUP_EN
    sat_last_d = sat_last_q;
`endif

    if (err_vld && (state_q != IDLE)) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (err_vld) begin
          err_cur_d = err_sat;
          busy_d    = 1'b1;
          state_d   = MUL_P;
        end
      end
      MUL_P: begin
        p_d     = P_W'(mul_prod);
        state_d = MUL_D;
      end
      MUL_D: begin
        d_d        = D_W'(mul_prod);
        prev_err_d = err_cur_q;
        state_d    = INTEG;
      end
      INTEG: begin
        if (!moving) begin
          integ_d = '0;
`ifdef PID_ANTIWINDUP_EN
        end else if (!sat_last_q) begin
`else
        end else begin
`endif
          integ_d = integ_clip;
        end
        state_d = SUM;
      end
      SUM: begin
        pid_out_d  = sum_clip;
        pid_vld_d  = 1'b1;
        busy_d     = 1'b0;
`ifdef PID_ANTIWINDUP_EN
        sat_last_d = sum_sat;
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_cur_q  <= '0;
      prev_err_q <= '0;
      p_q        <= '0;
      d_q        <= '0;
      integ_q    <= '0;
      pid_out_q  <= '0;
      pid_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef PID_ANTIWINDUP_EN
      sat_last_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      state_q    <= state_d;
      err_cur_q  <= err_cur_d;
      prev_err_q <= prev_err_d;
      p_q        <= p_d;
      d_q        <= d_d;
      integ_q    <= integ_d;
      pid_out_q  <= pid_out_d;
      pid_vld_q  <= pid_vld_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
`ifdef PID_ANTIWINDUP_EN
      sat_last_q <= sat_last_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign pid_out = pid_out_q;
  assign pid_vld = pid_vld_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq: table of single-sample transactions plus hand-written
// sequences for overrun, back-to-back strobes and reset in the middle of an operation.
module tb_pid_seq;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic signed [9:0] err_sat = '0;
  logic              err_vld = 1'b0;
  logic              moving  = 1'b1;
  logic              busy;
  logic signed [11:0] pid_out;
  logic              pid_vld;
  logic              ovr;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pid_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .err_sat (err_sat),
    .err_vld (err_vld),
    .moving  (moving),
    .busy    (busy),
    .pid_out (pid_out),
    .pid_vld (pid_vld),
    .ovr     (ovr)
  );

  typedef struct {
    bit do_rst;
    bit mv;
    int err;
    int exp_out;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    err_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One strobe, then wait (bounded) for pid_vld; lat is negedges after the strobe clears.
  task automatic run_sample(input int e, output int lat, output int val);
    @(negedge clk);
    err_sat = 10'(e);
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    lat = -1;
    val = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (pid_vld) begin
        lat = k;
        val = pid_out;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int val;
    int vld_seen;

    vecs[0]  = '{1'b1, 1'b1,  100,   999};
    vecs[1]  = '{1'b0, 1'b1,  100,   312};
    vecs[2]  = '{1'b1, 1'b1, -512, -2048};
`ifdef PID_ANTIWINDUP_EN
    vecs[3]  = '{1'b0, 1'b1, -512, -1568};
`else
    vecs[3]  = '{1'b0, 1'b1, -512, -1600};
`endif
    vecs[4]  = '{1'b1, 1'b0,  100,   993};
    vecs[5]  = '{1'b0, 1'b0, -100, -1004};
    vecs[6]  = '{1'b1, 1'b1,   50,   703};
    vecs[7]  = '{1'b0, 1'b1,   60,   296};
    vecs[8]  = '{1'b0, 1'b1,  -60,  -881};
    vecs[9]  = '{1'b1, 1'b1,  -20,  -282};
    vecs[10] = '{1'b1, 1'b1,  511,  2047};
`ifdef PID_ANTIWINDUP_EN
    vecs[11] = '{1'b0, 1'b1,  511,  1564};
`else
    vecs[11] = '{1'b0, 1'b1,  511,  1596};
`endif

    // Reset values while reset is held.
    #12;
    check("rst pid_out", int'(pid_out), 0);
    check("rst pid_vld", int'(pid_vld), 0);
    check("rst busy",    int'(busy), 0);
    check("rst ovr",     int'(ovr), 0);
    check("rst state",   int'(dut.state_q), int'(pid_pkg::IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_rst) do_reset();
      moving = vecs[i].mv;
      run_sample(vecs[i].err, lat, val);
      check($sformatf("v%0d latency", i), lat, 4);
      check($sformatf("v%0d pid_out", i), val, vecs[i].exp_out);
      check($sformatf("v%0d busy_done", i), int'(busy), 0);
      check($sformatf("v%0d ovr", i), int'(ovr), 0);
      @(negedge clk);
      check($sformatf("v%0d vld_pulse", i), int'(pid_vld), 0);
      check($sformatf("v%0d out_hold", i), int'(pid_out), vecs[i].exp_out);
    end

    // Overrun: strobes during MUL_D and during SUM are ignored but flag ovr.
    do_reset();
    moving = 1'b1;
    @(negedge clk);
    err_sat = 10'sd100;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    check("t4 busy MUL_P", int'(busy), 1);
    @(negedge clk);
    err_sat = -10'sd300;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    check("t4 ovr set", int'(ovr), 1);
    @(negedge clk);
    check("t4 busy SUM", int'(busy), 1);
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    check("t4 pid_vld", int'(pid_vld), 1);
    check("t4 pid_out", int'(pid_out), 999);
    check("t4 busy after SUM", int'(busy), 0);
    @(negedge clk);
    check("t4 SUM strobe ignored", int'(busy), 0);
    check("t4 ovr sticky", int'(ovr), 1);
    run_sample(100, lat, val);
    check("t4 follow latency", lat, 4);
    check("t4 follow pid_out", val, 312);
    check("t4 ovr still set", int'(ovr), 1);
    do_reset();
    check("t4 ovr cleared", int'(ovr), 0);

    // Reset asserted during SUM: no pulse, outputs cleared, state IDLE.
    moving = 1'b1;
    run_sample(100, lat, val);
    check("t6 pre pid_out", val, 999);
    @(negedge clk);
    err_sat = 10'sd100;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 in SUM", int'(dut.state_q), int'(pid_pkg::SUM));
    rst_n = 1'b0;
    #1;
    check("t6 pid_out", int'(pid_out), 0);
    check("t6 pid_vld", int'(pid_vld), 0);
    check("t6 busy",    int'(busy), 0);
    check("t6 ovr",     int'(ovr), 0);
    check("t6 state",   int'(dut.state_q), int'(pid_pkg::IDLE));
    vld_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (pid_vld) vld_seen = 1;
    end
    check("t6 no pid_vld", vld_seen, 0);
    check("t6 out after", int'(pid_out), 0);
    run_sample(100, lat, val);
    check("t6 fresh latency", lat, 4);
    check("t6 fresh pid_out", val, 999);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
